// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: sequences read/write/clear-all commands
// onto a single-port RAM with registered port signals.
module ram_access_ctrl #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  err,
  output logic                  mem_sel,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  mem_clr,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ISSUE,
    RD_CAP,
    RSP,
    CLR
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
  logic                  sel_nxt;
  logic                  clr_nxt;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [DATA_WIDTH-1:0] din_nxt;
  logic                  rvld_nxt;
  logic [DATA_WIDTH-1:0] rdata_nxt;
  logic                  err_nxt;
  logic                  acc;
  logic                  op_rd, op_wr, op_clr, op_rsv;

  assign cmd_ready = (state == IDLE);
  assign acc       = cmd_valid && cmd_ready;

  assign op_rd  = (cmd_op == 2'b00);
  assign op_wr  = (cmd_op == 2'b01);
  assign op_clr = (cmd_op == 2'b10);
  assign op_rsv = (cmd_op == 2'b11);

  // Next state and next values of every registered output
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sel_nxt   = mem_sel;
    clr_nxt   = mem_clr;
    addr_nxt  = mem_addr;
    din_nxt   = mem_din;
    rvld_nxt  = rsp_valid;
    rdata_nxt = rsp_data;
    err_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        sel_nxt = 1'b0;
        clr_nxt = 1'b0;
        if (acc) begin
          unique case (1'b1)
            op_rd: begin
              state_nxt = RD_ISSUE;
              addr_nxt  = cmd_addr;
            end
            op_wr: begin
              state_nxt = WR;
              sel_nxt   = 1'b1;
              addr_nxt  = cmd_addr;
              din_nxt   = cmd_wdata;
            end
            op_clr: begin
              state_nxt = CLR;
              clr_nxt   = 1'b1;
              addr_nxt  = '0;
              cnt_nxt   = '0;
            end
            op_rsv: begin
              err_nxt = 1'b1;
            end
          endcase
        end
      end
      WR: begin
        sel_nxt   = 1'b0;
        state_nxt = IDLE;
      end
      RD_ISSUE: begin
        state_nxt = RD_CAP;
      end
      RD_CAP: begin
        rdata_nxt = mem_dout;
        rvld_nxt  = 1'b1;
        state_nxt = RSP;
      end
      RSP: begin
        if (rsp_ready) begin
          rvld_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      CLR: begin
        if (&cnt) begin
          clr_nxt   = 1'b0;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt  = cnt + ADDR_WIDTH'(1);
          addr_nxt = cnt + ADDR_WIDTH'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        sel_nxt   = 1'b0;
        clr_nxt   = 1'b0;
        rvld_nxt  = 1'b0;
      end
    endcase
  end

  // State, clear counter and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      mem_sel   <= 1'b0;
      mem_clr   <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      mem_sel   <= sel_nxt;
      mem_clr   <= clr_nxt;
      mem_addr  <= addr_nxt;
      mem_din   <= din_nxt;
      rsp_valid <= rvld_nxt;
      rsp_data  <= rdata_nxt;
      err       <= err_nxt;
    end
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb_ram_access_ctrl: directed bench with a behavioural RAM
// and a read-response scoreboard.
module tb_ram_access_ctrl;

  localparam int AW = 2;
  localparam int DW = 4;
  localparam int DEPTH = 2**AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_data;
  logic          err;
  logic          mem_sel;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic          mem_clr;
  logic [DW-1:0] mem_dout;

  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] shd [DEPTH];
  logic [DW-1:0] q [$];

  int nchk = 0;
  int nfail = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  ram_access_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .err       (err),
    .mem_sel   (mem_sel),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_clr   (mem_clr),
    .mem_dout  (mem_dout)
  );

  // Single-port RAM: per-address clear, write, else registered read
  always @(posedge clk) begin
    if (mem_clr) ram[mem_addr] <= '0;
    else if (mem_sel) ram[mem_addr] <= mem_din;
    else mem_dout <= ram[mem_addr];
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op,
                       input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    int n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_wdata = d;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a,
                    input logic [DW-1:0] d);
    issue(2'b01, a, d);
    chk("wr_sel", mem_sel, 1);
    chk("wr_addr", mem_addr, a);
    chk("wr_din", mem_din, d);
    chk("wr_busy", cmd_ready, 0);
    chk("wr_noclr", mem_clr, 0);
    @(negedge clk);
    chk("wr_sel_drop", mem_sel, 0);
    chk("wr_ready", cmd_ready, 1);
    chk("wr_addr_hold", mem_addr, a);
    shd[a] = d;
  endtask

  task automatic rd(input logic [AW-1:0] a, input int hold);
    int n;
    logic [DW-1:0] e;
    q.push_back(shd[a]);
    rsp_ready = (hold == 0);
    issue(2'b00, a, '0);
    n = 1;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rd_latency", n, 3);
    e = q.pop_front();
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'b1;
      cmd_op    = 2'b01;
      cmd_addr  = a;
      cmd_wdata = ~shd[a];
      chk("hold_valid", rsp_valid, 1);
      chk("hold_data", rsp_data, e);
      chk("hold_busy", cmd_ready, 0);
      chk("hold_nosel", mem_sel, 0);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_data", rsp_data, e);
    @(negedge clk);
    chk("rsp_done", rsp_valid, 0);
    chk("rsp_ready_back", cmd_ready, 1);
  endtask

  task automatic clr_all(input int abort);
    issue(2'b10, '0, '0);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == abort) begin
        reset = 1'b1;
        #1;
        chk("abort_clr", mem_clr, 0);
        chk("abort_ready", cmd_ready, 1);
        chk("abort_addr", mem_addr, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        return;
      end
      chk("clr_on", mem_clr, 1);
      chk("clr_addr", mem_addr, i);
      chk("clr_nosel", mem_sel, 0);
      chk("clr_busy", cmd_ready, 0);
      shd[i] = '0;
      @(negedge clk);
    end
    chk("clr_off", mem_clr, 0);
    chk("clr_ready", cmd_ready, 1);
  endtask

  initial begin
    int c0;
    for (int i = 0; i < DEPTH; i++) begin
      ram[i] = '0;
      shd[i] = '0;
    end
    mem_dout = '0;

    repeat (2) @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_rvalid", rsp_valid, 0);
    chk("rst_rdata", rsp_data, 0);
    chk("rst_err", err, 0);
    chk("rst_sel", mem_sel, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_din", mem_din, 0);
    chk("rst_clr", mem_clr, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", cmd_ready, 1);
    chk("post_rst_sel", mem_sel, 0);

    wr(2, 4'hA);
    rd(2, 0);

    for (int i = 0; i < DEPTH; i++) wr(AW'(i), DW'(i + 1));
    c0 = cyc;
    for (int i = 0; i < DEPTH; i++) rd(AW'(i), 0);
    chk("rd_throughput", cyc - c0, 4 * DEPTH);

    rd(1, 5);
    rd(0, 0);

    for (int i = 0; i < DEPTH; i++) wr(AW'(i), 4'hF);
    clr_all(DEPTH);
    for (int i = 0; i < DEPTH; i++) rd(AW'(i), 0);

    wr(1, 4'h9);
    issue(2'b11, 1, 4'h7);
    chk("err_pulse", err, 1);
    chk("err_nosel", mem_sel, 0);
    chk("err_noclr", mem_clr, 0);
    chk("err_ready", cmd_ready, 1);
    @(negedge clk);
    chk("err_drop", err, 0);
    rd(1, 0);

    for (int i = 0; i < DEPTH; i++) wr(AW'(i), 4'hF);
    clr_all(2);
    chk("abort_rvalid", rsp_valid, 0);
    for (int i = 0; i < DEPTH; i++) rd(AW'(i), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
